// File: rtl/mem_io_responder.sv
// Byte-wide memory responder: synchronous RAM plus a UART IO window.
// Holds the TX/RX FIFOs, the overflow flag and the program-finish strobe.
module mem_io_responder #(
  parameter int          ADDR_WIDTH = 17,
  parameter logic [31:0] IO_BASE    = 32'h30000,
  parameter int          TX_DEPTH   = 8,
  parameter int          RX_DEPTH   = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        prog_finish,
  output logic        tx_overflow
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0] TX_FULL_N = (TAW+1)'(TX_DEPTH);
  localparam logic [TAW:0] TX_NEAR_N = (TAW+1)'(TX_DEPTH-1);
  localparam logic [RAW:0] RX_FULL_N = (RAW+1)'(RX_DEPTH);

  logic [7:0] r_ram [2**ADDR_WIDTH];
  logic [7:0] r_tx_mem [TX_DEPTH];
  logic [7:0] r_rx_mem [RX_DEPTH];

  logic [TAW-1:0] r_tx_wr, r_tx_rd;
  logic [TAW:0]   r_tx_cnt;
  logic [RAW-1:0] r_rx_wr, r_rx_rd;
  logic [RAW:0]   r_rx_cnt;
  logic [7:0]     r_din;
  logic           r_pf;
  logic           r_ovf;

  logic [ADDR_WIDTH-1:0] w_idx;
  logic w_io, w_off0, w_off4;
  logic w_tx_full, w_rx_empty, w_rx_full;
  logic w_tx_push, w_tx_pop, w_tx_drop;
  logic w_rx_push, w_rx_pop;
  logic w_ram_we, w_rd_ram, w_rd_rx, w_rd_st;
  logic w_unused;

  assign w_unused = ^mem_a[31:18];

  assign w_idx  = mem_a[ADDR_WIDTH-1:0];
  assign w_io   = (mem_a[17:16] == IO_BASE[17:16]);
  assign w_off0 = (mem_a[2:0] == 3'd0);
  assign w_off4 = (mem_a[2:0] == 3'd4);

  assign w_tx_full  = (r_tx_cnt == TX_FULL_N);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == RX_FULL_N);

  assign w_tx_push = rdy_in && mem_wr && w_io && w_off0 && !w_tx_full;
  assign w_tx_drop = rdy_in && mem_wr && w_io && w_off0 && w_tx_full;
  assign w_tx_pop  = rdy_in && tx_valid && tx_ready;
  assign w_rx_push = rdy_in && rx_valid && !w_rx_full;
  assign w_rx_pop  = rdy_in && w_rd_rx && !w_rx_empty;
  assign w_ram_we  = rdy_in && mem_wr && !w_io;

  assign w_rd_ram = !mem_wr && !w_io;
  assign w_rd_rx  = !mem_wr && w_io && w_off0;
  assign w_rd_st  = !mem_wr && w_io && w_off4;

  assign mem_din        = r_din;
  assign io_buffer_full = (r_tx_cnt >= TX_NEAR_N);
  assign tx_data        = r_tx_mem[r_tx_rd];
  assign tx_valid       = (r_tx_cnt != '0);
  assign rx_ready       = !w_rx_full;
  assign prog_finish    = r_pf;
  assign tx_overflow    = r_ovf;

  // Storage arrays carry no reset; only pointers and counts do.
  always_ff @(posedge clk_in) begin
    if (w_ram_we)  r_ram[w_idx]      <= mem_dout;
    if (w_tx_push) r_tx_mem[r_tx_wr] <= mem_dout;
    if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_data;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_din <= '0;
      r_pf  <= 1'b0;
    end else begin
      r_pf <= rdy_in && mem_wr && w_io && w_off4;
      if (rdy_in) begin
        unique case (1'b1)
          w_rd_ram: r_din <= r_ram[w_idx];
          w_rd_rx:  r_din <= w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd];
          w_rd_st:  r_din <= {6'b0, !w_rx_empty, w_tx_full};
          default:  r_din <= 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_tx_cnt <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_tx_drop) r_ovf   <= 1'b1;
      if (w_tx_push) r_tx_wr <= r_tx_wr + TAW'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + TAW'(1);
      unique case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + (TAW+1)'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - (TAW+1)'(1);
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + RAW'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + RAW'(1);
      unique case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + (RAW+1)'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - (RAW+1)'(1);
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, IO window, FIFOs,
// strobe, rdy gating and asynchronous reset.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        prog_finish;
  logic        tx_overflow;

  int checks = 0;
  int errors = 0;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .prog_finish(prog_finish), .tx_overflow(tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic bus(input logic [31:0] a, input logic wr,
                     input logic [7:0] d);
    mem_a = a;
    mem_wr = wr;
    mem_dout = d;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus(32'h100, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    rdy_in = 1'b1;
    mem_a = 32'h100;
    mem_wr = 1'b0;
    mem_dout = 8'h00;
    tx_ready = 1'b0;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    #12;
    checks++;
    if (mem_din !== 8'h00) begin
      errors++;
      $display("FAIL rst_din: got %h exp 00", mem_din);
    end
    checks++;
    if ({tx_valid, rx_ready, io_buffer_full, prog_finish, tx_overflow}
        !== 5'b01000) begin
      errors++;
      $display("FAIL rst_flags: got %b exp 01000",
        {tx_valid, rx_ready, io_buffer_full, prog_finish, tx_overflow});
    end
    rst_n_in = 1'b1;
    #1;
  endtask

  task automatic test_write_read();
    bus(32'h10, 1'b1, 8'hA5);
    checks++;
    if (mem_din !== 8'h00) begin
      errors++;
      $display("FAIL wr_din: got %h exp 00", mem_din);
    end
    bus(32'h10, 1'b0, 8'h00);
    checks++;
    if (mem_din !== 8'hA5) begin
      errors++;
      $display("FAIL rd_after_wr: got %h exp a5", mem_din);
    end
  endtask

  task automatic test_burst();
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) bus(32'h100 + i, 1'b1, exp[i]);
    for (int i = 0; i < 4; i++) begin
      bus(32'h100 + i, 1'b0, 8'h00);
      checks++;
      if (mem_din !== exp[i]) begin
        errors++;
        $display("FAIL burst[%0d]: got %h exp %h", i, mem_din, exp[i]);
      end
    end
  endtask

  task automatic test_tx_fill();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus(32'h30000, 1'b1, 8'h50 + 8'(i));
      if (i == 5 || i == 6) begin
        checks++;
        if (io_buffer_full !== (i == 6)) begin
          errors++;
          $display("FAIL ibf[%0d]: got %b exp %b", i, io_buffer_full, i == 6);
        end
      end
      if (i == 7 || i == 8) begin
        checks++;
        if (tx_overflow !== (i == 8)) begin
          errors++;
          $display("FAIL ovf[%0d]: got %b exp %b", i, tx_overflow, i == 8);
        end
      end
    end
    bus(32'h30004, 1'b0, 8'h00);
    checks++;
    if (mem_din !== 8'h01) begin
      errors++;
      $display("FAIL st_txfull: got %h exp 01", mem_din);
    end
    idle();
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h50 + 8'(i)) begin
        errors++;
        $display("FAIL drain[%0d]: got v=%b d=%h exp v=1 d=%h",
          i, tx_valid, tx_data, 8'h50 + 8'(i));
      end
      idle();
    end
    checks++;
    if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0 || tx_overflow !== 1'b1) begin
      errors++;
      $display("FAIL drained: got v=%b ibf=%b ovf=%b exp 0 0 1",
        tx_valid, io_buffer_full, tx_overflow);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_rx();
    rx_data = 8'h41;
    rx_valid = 1'b1;
    idle();
    rx_valid = 1'b0;
    bus(32'h30000, 1'b0, 8'h00);
    checks++;
    if (mem_din !== 8'h41) begin
      errors++;
      $display("FAIL rx_rd: got %h exp 41", mem_din);
    end
    bus(32'h30000, 1'b0, 8'h00);
    checks++;
    if (mem_din !== 8'h00) begin
      errors++;
      $display("FAIL rx_empty: got %h exp 00", mem_din);
    end
    bus(32'h30004, 1'b0, 8'h00);
    checks++;
    if (mem_din !== 8'h00) begin
      errors++;
      $display("FAIL st_idle: got %h exp 00", mem_din);
    end
    rx_data = 8'h01;
    rx_valid = 1'b1;
    idle();
    rx_data = 8'h02;
    bus(32'h30000, 1'b0, 8'h00);
    rx_valid = 1'b0;
    checks++;
    if (mem_din !== 8'h01) begin
      errors++;
      $display("FAIL rx_sim1: got %h exp 01", mem_din);
    end
    bus(32'h30000, 1'b0, 8'h00);
    checks++;
    if (mem_din !== 8'h02) begin
      errors++;
      $display("FAIL rx_sim2: got %h exp 02", mem_din);
    end
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'h61 + 8'(i);
      idle();
    end
    rx_valid = 1'b0;
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL rx_full: got %b exp 0", rx_ready);
    end
    for (int i = 0; i < 5; i++) begin
      bus(32'h30000, 1'b0, 8'h00);
      checks++;
      if (mem_din !== ((i < 4) ? 8'h61 + 8'(i) : 8'h00)) begin
        errors++;
        $display("FAIL rx_pop[%0d]: got %h exp %h", i, mem_din,
          (i < 4) ? 8'h61 + 8'(i) : 8'h00);
      end
    end
  endtask

  task automatic test_prog_finish();
    bus(32'h30004, 1'b1, 8'h00);
    checks++;
    if (prog_finish !== 1'b1) begin
      errors++;
      $display("FAIL pf_hi: got %b exp 1", prog_finish);
    end
    idle();
    checks++;
    if (prog_finish !== 1'b0) begin
      errors++;
      $display("FAIL pf_lo: got %b exp 0", prog_finish);
    end
    rdy_in = 1'b0;
    bus(32'h30004, 1'b1, 8'h00);
    checks++;
    if (prog_finish !== 1'b0) begin
      errors++;
      $display("FAIL pf_rdy: got %b exp 0", prog_finish);
    end
    rdy_in = 1'b1;
  endtask

  task automatic test_rdy_hold();
    bus(32'h101, 1'b0, 8'h00);
    rdy_in = 1'b0;
    bus(32'h10, 1'b1, 8'h77);
    checks++;
    if (mem_din !== 8'h22) begin
      errors++;
      $display("FAIL rdy_hold: got %h exp 22", mem_din);
    end
    rdy_in = 1'b1;
    bus(32'h10, 1'b0, 8'h00);
    checks++;
    if (mem_din !== 8'hA5) begin
      errors++;
      $display("FAIL rdy_nowr: got %h exp a5", mem_din);
    end
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus(32'h30000, 1'b1, 8'h90 + 8'(i));
    bus(32'h10, 1'b0, 8'h00);
    tx_ready = 1'b1;
    bus(32'h10, 1'b0, 8'h00);
    checks++;
    if (tx_valid !== 1'b1 || mem_din !== 8'hA5) begin
      errors++;
      $display("FAIL pre_rst: got v=%b d=%h exp v=1 d=a5", tx_valid, mem_din);
    end
    #2 rst_n_in = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || mem_din !== 8'h00 || tx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst: got v=%b d=%h ovf=%b exp 0 00 0",
        tx_valid, mem_din, tx_overflow);
    end
    rst_n_in = 1'b1;
    tx_ready = 1'b0;
    bus(32'h10, 1'b0, 8'h00);
    checks++;
    if (mem_din !== 8'hA5) begin
      errors++;
      $display("FAIL ram_keep: got %h exp a5", mem_din);
    end
    bus(32'h102, 1'b0, 8'h00);
    checks++;
    if (mem_din !== 8'h33 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL ram_keep2: got d=%h v=%b exp 33 0", mem_din, tx_valid);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_burst();
    test_tx_fill();
    test_rx();
    test_prog_finish();
    test_rdy_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
